inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL: clk_i  input  1  single clock; all state updates on posedge.
REQ-002 SHALL: rst_i  input  1  reset, asynchronous, active-low (`RESET_EDGE / `RESET_ON from define.h).
REQ-003 SHALL: Mem_addr_o  output  5  instruction-memory word address.
REQ-004 SHALL: Mem_read_en_o  output  1  read request to instruction memory.
REQ-005 SHALL: Mem_read_data_i  input  `dw  instruction word returned by memory.
REQ-006 SHALL: Inst_valid_o  output  1  Inst_o/Inst_pc_o hold a valid instruction.
REQ-007 SHALL: Inst_ready_i  input  1  downstream decode accepts; transfer = Inst_valid_o & Inst_ready_i.
REQ-008 SHALL: Inst_o  output  `dw  fetched instruction word.
REQ-009 SHALL: Inst_pc_o  output  5  word address of Inst_o.
REQ-010 SHALL: Redirect_en_i  input  1  branch/jump redirect, one-cycle pulse.
REQ-011 SHALL: Redirect_pc_i  input  5  redirect target word address.
REQ-012 SHALL: Halted_o  output  1  fetch unit in HALT state.

Function
REQ-013 SHALL: states IDLE (post-reset), FETCH, HALT; IDLE->FETCH unconditionally on first posedge after reset release.
REQ-014 SHALL: memory latency one cycle: data for a request registered at posedge N is captured from Mem_read_data_i at posedge N+1.
REQ-015 SHALL: Mem_read_en_o and Mem_addr_o registered; Mem_read_en_o=0 forces no capture next cycle.
REQ-016 SHALL: 2-entry instruction FIFO {word, pc}; head drives Inst_o/Inst_pc_o; Inst_valid_o = FIFO non-empty.
REQ-017 SHALL: new request issued only if (FIFO count + in-flight count - transfer this cycle) < 2; FIFO never overflows, no response ever dropped except on flush.
REQ-018 SHALL: fetch PC increments by 1 per issued request, 5-bit wrap 31->0.
REQ-019 SHALL: sustained throughput 1 instruction/cycle while Inst_ready_i=1.
REQ-020 SHALL: Inst_ready_i=0 holds Inst_o/Inst_pc_o/Inst_valid_o stable until transfer.
REQ-021 SHALL: Redirect_en_i=1 at posedge N: FIFO flushed, in-flight response discarded at N+1, Mem_addr_o=Redirect_pc_i with Mem_read_en_o=1 at N+1; Inst_valid_o=0 during cycle N+1.
REQ-022 SHALL: redirect wins over simultaneous transfer, capture, or issue; redirect in HALT returns to FETCH.
REQ-023 SHALL: simultaneous capture and transfer with FIFO full-1 keeps count unchanged.

Reset
REQ-024 SHALL: async assert of rst_i forces Mem_read_en_o=0, Mem_addr_o=0, Inst_valid_o=0, Inst_o=`ZERO, Inst_pc_o=0, Halted_o=0, FIFO empty, in-flight cleared, PC=0, state IDLE.
REQ-025 SHALL: reset mid-operation discards all buffered and in-flight instructions; fetch restarts at address 0.

Configuration
REQ-026 SHALL: macro FETCH_HALT_ON_ZERO_EN defined: captured word == `ZERO is not enqueued, state -> HALT, Halted_o=1, Mem_read_en_o=0 until redirect; older FIFO entries still drain.
REQ-027 SHALL: macro undefined: `ZERO words treated as ordinary instructions, HALT unreachable, Halted_o tied 0.

Verification
REQ-028 SHALL: reset release, Inst_ready_i=1, memory 0..2 = 0x00002083, 0x00102103, 0x002081B3 -> Inst_o sequence with Inst_pc_o 0,1,2 on consecutive cycles, first Inst_valid_o=1 at third posedge after release.
REQ-029 SHALL: Inst_ready_i=0 for 5 cycles mid-stream -> at most 2 words buffered, Mem_read_en_o=0 while full, no lost/duplicated pc on resume.
REQ-030 SHALL: Redirect_en_i=1, Redirect_pc_i=20 while request to pc 7 in flight -> pc 7 word never delivered, next delivered Inst_pc_o=20.
REQ-031 SHALL: run from pc 30 -> Inst_pc_o 30, 31, 0, 1.
REQ-032 SHALL: with FETCH_HALT_ON_ZERO_EN, pc 3 holds `ZERO -> pcs 0..2 delivered, Halted_o=1, Mem_read_en_o=0; redirect to 0 resumes; without macro pc 3 delivered as 0x00000000.
REQ-033 SHALL: rst_i asserted with 2 entries buffered -> all outputs at reset values immediately, first post-reset Inst_pc_o=0.

Source files
------------

// File: rtl/inst_fetch.sv
// ============================================================================
// Module   : inst_fetch
// Brief    : Instruction fetch unit, 1-cycle memory, 2-entry buffer, redirect.
//            Optional FETCH_HALT_ON_ZERO_EN: an all-zero word halts fetch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_fetch #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [4:0]    Mem_addr_o,
    output logic          Mem_read_en_o,
    input  logic [DW-1:0] Mem_read_data_i,
    output logic          Inst_valid_o,
    input  logic          Inst_ready_i,
    output logic [DW-1:0] Inst_o,
    output logic [4:0]    Inst_pc_o,
    input  logic          Redirect_en_i,
    input  logic [4:0]    Redirect_pc_i,
    output logic          Halted_o
);

    localparam logic [DW-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    pc_q, pc_d;
    logic          req_en_q, req_en_d;
    logic [4:0]    req_addr_q, req_addr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] word0_q, word0_d, word1_q, word1_d;
    logic [4:0]    pc0_q, pc0_d, pc1_q, pc1_d;

    logic          pop, push, zero_hit, room;
    logic [1:0]    cnt_after_pop;
    logic [2:0]    occupancy;

    assign Mem_addr_o    = req_addr_q;
    assign Mem_read_en_o = req_en_q;
    assign Inst_valid_o  = (cnt_q != 2'd0);
    assign Inst_o        = word0_q;
    assign Inst_pc_o     = pc0_q;

`ifdef FETCH_HALT_ON_ZERO_EN
    assign zero_hit = req_en_q && (Mem_read_data_i == ZERO);
    assign Halted_o = (state_q == S_HALT);
`else
    assign zero_hit = 1'b0;
    assign Halted_o = 1'b0;
`endif

    assign pop           = Inst_valid_o & Inst_ready_i;
    assign push          = req_en_q & ~zero_hit;
    assign cnt_after_pop = cnt_q - {1'b0, pop};
    // Buffered plus outstanding, after this cycle's hand-off, must leave a slot.
    assign occupancy     = {1'b0, cnt_q} + {2'b0, req_en_q} - {2'b0, pop};
    assign room          = (occupancy < 3'd2);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_en_d   = 1'b0;
        req_addr_d = req_addr_q;
        cnt_d      = cnt_q;
        word0_d    = word0_q;
        word1_d    = word1_q;
        pc0_d      = pc0_q;
        pc1_d      = pc1_q;

        if (Redirect_en_i) begin
            cnt_d      = 2'd0;
            state_d    = S_FETCH;
            req_en_d   = 1'b1;
            req_addr_d = Redirect_pc_i;
            pc_d       = Redirect_pc_i + 5'd1;
        end else begin
            if (pop) begin
                word0_d = word1_q;
                pc0_d   = pc1_q;
            end
            if (push) begin
                if (cnt_after_pop == 2'd0) begin
                    word0_d = Mem_read_data_i;
                    pc0_d   = req_addr_q;
                end else begin
                    word1_d = Mem_read_data_i;
                    pc1_d   = req_addr_q;
                end
            end
            cnt_d = cnt_after_pop + {1'b0, push};

            case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    if (zero_hit) begin
                        state_d = S_HALT;
                    end else if (room) begin
                        req_en_d   = 1'b1;
                        req_addr_d = pc_q;
                        pc_d       = pc_q + 5'd1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= 5'd0;
            req_en_q   <= 1'b0;
            req_addr_q <= 5'd0;
            cnt_q      <= 2'd0;
            word0_q    <= ZERO;
            word1_q    <= ZERO;
            pc0_q      <= 5'd0;
            pc1_q      <= 5'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_en_q   <= req_en_d;
            req_addr_q <= req_addr_d;
            cnt_q      <= cnt_d;
            word0_q    <= word0_d;
            word1_q    <= word1_d;
            pc0_q      <= pc0_d;
            pc1_q      <= pc1_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module   : tb_inst_fetch
// Brief    : Scoreboard bench for inst_fetch with a 1-cycle memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  Mem_addr_o;
    logic        Mem_read_en_o;
    logic [31:0] Mem_read_data_i;
    logic        Inst_valid_o;
    logic        Inst_ready_i;
    logic [31:0] Inst_o;
    logic [4:0]  Inst_pc_o;
    logic        Redirect_en_i;
    logic [4:0]  Redirect_pc_i;
    logic        Halted_o;

    inst_fetch #(.DW(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .Mem_addr_o      (Mem_addr_o),
        .Mem_read_en_o   (Mem_read_en_o),
        .Mem_read_data_i (Mem_read_data_i),
        .Inst_valid_o    (Inst_valid_o),
        .Inst_ready_i    (Inst_ready_i),
        .Inst_o          (Inst_o),
        .Inst_pc_o       (Inst_pc_o),
        .Redirect_en_i   (Redirect_en_i),
        .Redirect_pc_i   (Redirect_pc_i),
        .Halted_o        (Halted_o)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] mem [32];
    assign Mem_read_data_i = mem[Mem_addr_o];

    typedef struct packed {
        logic [4:0]  pc;
        logic [31:0] w;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   next_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] pc);
        exp_q.push_back({pc, mem[pc]});
    endtask

    task automatic wait_empty(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic redirect(input logic [4:0] pc);
        Redirect_en_i = 1'b1;
        Redirect_pc_i = pc;
        tick();
        Redirect_en_i = 1'b0;
    endtask

    // Monitor: every hand-off seen on the falling edge must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i && Inst_valid_o && Inst_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_transfer: got pc %0d word %0h, required none",
                             Inst_pc_o, Inst_o);
                end else begin
                    e = exp_q.pop_front();
                    check("deliver_pc", {27'd0, Inst_pc_o}, {27'd0, e.pc});
                    check("deliver_word", Inst_o, e.w);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 | i;
        mem[0] = 32'h0000_2083;
        mem[1] = 32'h0010_2103;
        mem[2] = 32'h0020_81B3;
        mem[3] = 32'h0000_0000;

        rst_i         = 1'b0;
        Inst_ready_i  = 1'b1;
        Redirect_en_i = 1'b0;
        Redirect_pc_i = 5'd0;
        repeat (3) tick();

        check("rst_read_en", {31'd0, Mem_read_en_o}, 0);
        check("rst_addr", {27'd0, Mem_addr_o}, 0);
        check("rst_valid", {31'd0, Inst_valid_o}, 0);
        check("rst_inst", Inst_o, 0);
        check("rst_pc", {27'd0, Inst_pc_o}, 0);
        check("rst_halted", {31'd0, Halted_o}, 0);

        // Straight-line fetch from address 0
        push_exp(5'd0); push_exp(5'd1); push_exp(5'd2);
`ifndef FETCH_HALT_ON_ZERO_EN
        push_exp(5'd3); push_exp(5'd4); push_exp(5'd5);
`endif
        rst_i = 1'b1;
        tick();
        check("valid_after_edge1", {31'd0, Inst_valid_o}, 0);
        tick();
        check("valid_after_edge2", {31'd0, Inst_valid_o}, 0);
        check("first_req_en", {31'd0, Mem_read_en_o}, 1);
        check("first_req_addr", {27'd0, Mem_addr_o}, 0);
        tick();
        check("valid_after_edge3", {31'd0, Inst_valid_o}, 1);
        check("pc_cycle3", {27'd0, Inst_pc_o}, 0);
        tick();
        check("pc_cycle4", {27'd0, Inst_pc_o}, 1);
        tick();
        check("pc_cycle5", {27'd0, Inst_pc_o}, 2);
        wait_empty("stream_drain", 40);
        Inst_ready_i = 1'b0;
`ifdef FETCH_HALT_ON_ZERO_EN
        repeat (2) tick();
        check("halted_set", {31'd0, Halted_o}, 1);
        check("halted_no_read", {31'd0, Mem_read_en_o}, 0);
        check("halted_empty", {31'd0, Inst_valid_o}, 0);
        redirect(5'd4);
        check("halt_released", {31'd0, Halted_o}, 0);
        next_pc = 4;
`else
        check("halted_tied_low", {31'd0, Halted_o}, 0);
        next_pc = 6;
`endif

        // Back-pressure: buffer fills, reads stop, head stays put
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {31'd0, Inst_valid_o}, 1);
            check("stall_pc", {27'd0, Inst_pc_o}, next_pc[4:0]);
        end
        check("stall_no_read", {31'd0, Mem_read_en_o}, 0);
        for (int i = 0; i < 4; i++) push_exp(5'(next_pc + i));
        Inst_ready_i = 1'b1;
        wait_empty("stall_resume", 40);
        Inst_ready_i = 1'b0;
        repeat (3) tick();

        // Redirect discards an in-flight request to pc 7
        redirect(5'd5);
        repeat (3) tick();
        push_exp(5'd5);
        Inst_ready_i = 1'b1;
        tick();
        Inst_ready_i = 1'b0;
        check("inflight_en", {31'd0, Mem_read_en_o}, 1);
        check("inflight_addr", {27'd0, Mem_addr_o}, 7);
        redirect(5'd20);
        check("redir_valid_low", {31'd0, Inst_valid_o}, 0);
        check("redir_addr", {27'd0, Mem_addr_o}, 20);
        check("redir_en", {31'd0, Mem_read_en_o}, 1);
        push_exp(5'd20); push_exp(5'd21); push_exp(5'd22);
        Inst_ready_i = 1'b1;
        wait_empty("redir_stream", 40);
        Inst_ready_i = 1'b0;
        repeat (3) tick();

        // Address wrap 31 -> 0
        redirect(5'd30);
        push_exp(5'd30); push_exp(5'd31); push_exp(5'd0); push_exp(5'd1);
        Inst_ready_i = 1'b1;
        wait_empty("wrap_stream", 40);
        Inst_ready_i = 1'b0;
        repeat (3) tick();

        // Asynchronous reset with the buffer occupied
        check("pre_reset_valid", {31'd0, Inst_valid_o}, 1);
        rst_i = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, Inst_valid_o}, 0);
        check("mid_rst_read_en", {31'd0, Mem_read_en_o}, 0);
        check("mid_rst_addr", {27'd0, Mem_addr_o}, 0);
        check("mid_rst_inst", Inst_o, 0);
        check("mid_rst_pc", {27'd0, Inst_pc_o}, 0);
        tick();
        push_exp(5'd0); push_exp(5'd1); push_exp(5'd2);
        Inst_ready_i = 1'b1;
        rst_i = 1'b1;
        wait_empty("post_reset_stream", 40);
        Inst_ready_i = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
